peak_finder_line: RTL
=====================

Name: peak_finder_line

Overview:
- Parametrised successor to the line-sensor maximum finder.
- Scans one sensor line per `start`..`line_end` window and tracks the maximum sample and the contiguous plateau of equal-maximum samples.
- Also reports the extent and count of samples above a programmable threshold.
- Sits between the pixel readout sequencer and the position-calculation logic; one registered result set per line, flagged by a single-cycle strobe.

Parameters:
- DW, 8: sample width (bits).
- PW, 9: pixel position width (bits).
- POS_MIN, 8: lowest accepted position (inclusive); masks dark/reference pixels.
- POS_MAX, 511: highest accepted position (inclusive).

Ports:
- clk_in  in  1  system clock, all logic on rising edge
- rst_n_in  in  1  asynchronous active-low reset
- start  in  1  begin new line; clears accumulators, latches threshold
- data_valid  in  1  data_in/data_pos/line_end qualifier
- data_in  in  DW  sample value
- data_pos  in  PW  sample position
- line_end  in  1  marks last sample of line (valid only with data_valid)
- threshold  in  DW  extent threshold, sampled on start
- busy  out  1  high while in SCAN
- result_valid  out  1  one-cycle pulse, results updated
- max_value  out  DW  maximum sample of line
- max_pos  out  PW  plateau midpoint, floor((plat_start+plat_end)/2)
- plateau_len  out  PW+1  plat_end-plat_start+1; 0 if no max found
- above_first  out  PW  first accepted position with data_in > threshold
- above_last  out  PW  last such position
- above_count  out  PW+1  number of such samples, saturating at all-ones

Behaviour:
- Async reset: state IDLE, all outputs 0, accumulators 0, latched threshold 0.
- States:
  - IDLE: waiting for `start`.
  - SCAN: accumulating samples.
  - DONE: single cycle; `result_valid`=1, then IDLE.
- Transitions:
  - `start` in any state -> clear accumulators, latch `threshold`, go SCAN.
  - SCAN and accepted sample with `line_end` -> DONE.
  - DONE and no `start` -> IDLE.
- Accepted sample: state SCAN, `data_valid`=1, `start`=0, POS_MIN <= `data_pos` <= POS_MAX. Anything else is ignored for the max, plateau and threshold statistics.
- A `line_end` sample outside the position window still ends the line; its data is not counted.
- Max tracking (cur_max initialised to 0, so zero-valued samples never register):
  - `data_in` > cur_max: cur_max <= `data_in`; plat_start = plat_end = `data_pos`; run_active <= 1.
  - `data_in` == cur_max, run_active, and `data_pos` == prev_pos+1: plat_end <= `data_pos`.
  - Any other accepted sample: run_active <= 0. A later disjoint equal plateau is ignored; the first plateau wins.
  - prev_pos = position of last accepted sample.
- Threshold tracking (strict `data_in` > latched threshold):
  - First hit sets above_first.
  - Every hit sets above_last and increments above_count, which saturates at 2^(PW+1)-1.
- Latency and output timing:
  - Output registers load at the same edge that accepts the `line_end` sample, including that sample's contribution.
  - `result_valid` is high for exactly the following cycle.
  - Outputs hold until the next result load or reset.
  - max_pos uses a PW+1-bit sum, shifted right by 1.
- No-hit cases:
  - No max found: max_value=0, max_pos=0, plateau_len=0.
  - No threshold hit: above_first=above_last=0, above_count=0.
- Simultaneous `start` and `line_end`: `start` wins; no result; sample discarded; new SCAN begins.
- `start` mid-SCAN: abort line silently (no `result_valid`); previous outputs unchanged.
- `line_end` or `data_valid` in IDLE or DONE: ignored.
- Reset mid-SCAN: immediate return to IDLE; no `result_valid`.
- `busy` is registered and equals (state==SCAN).

Test Plan:
- Window masking: `start`, `threshold`=50; positions 0..15 with data[3]=200, data[10]=90, others 10; `line_end` at pos 15 -> `result_valid` 1 cycle after pos-15 edge; max_value=90, max_pos=10, plateau_len=1, above_first=above_last=10, above_count=1.
- Plateau midpoint: values 120 at positions 20..25, 120 again at 40, others 5 -> max_value=120, max_pos=22, plateau_len=6; pos 40 ignored.
- Zero and no-hit line: all samples 0, `threshold`=0 -> every output 0, `result_valid` still pulses once.
- Abort and restart: `start`, 5 samples, `start` again together with a `line_end` sample, then full line with peak 77 at pos 100 -> exactly one `result_valid`; max_value=77, max_pos=100.
- Saturation and threshold latch: PW=3, POS_MIN=0, POS_MAX=7, 8 samples all 9, `threshold` changed to 255 after `start` -> above_count=8 (values 0..15 range; check no wrap); `threshold` used is the value at `start`.
- Async reset: assert `rst_n_in` mid-SCAN off-edge -> outputs 0 immediately, `busy`=0, no `result_valid` after release.

Source files
------------

// File: rtl/peak_finder_line.sv
// peak_finder_line: per-line maximum / plateau / threshold-extent finder.
// One line is scanned between a start pulse and an accepted line_end sample.
// Results load into output registers on the line_end edge and are flagged
// by a single-cycle result_valid strobe on the following cycle.
module peak_finder_line #(
    parameter int DW      = 8,
    parameter int PW      = 9,
    parameter int POS_MIN = 8,
    parameter int POS_MAX = 511
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          start,
    input  logic          data_valid,
    input  logic [DW-1:0] data_in,
    input  logic [PW-1:0] data_pos,
    input  logic          line_end,
    input  logic [DW-1:0] threshold,
    output logic          busy,
    output logic          result_valid,
    output logic [DW-1:0] max_value,
    output logic [PW-1:0] max_pos,
    output logic [PW:0]   plateau_len,
    output logic [PW-1:0] above_first,
    output logic [PW-1:0] above_last,
    output logic [PW:0]   above_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [PW:0] ONE_P = {{PW{1'b0}}, 1'b1};

    // state and control
    logic [1:0]    r_state;
    logic [1:0]    w_nxt_state;
    logic          r_busy;
    logic          r_result_valid;
    logic          w_ge_min;
    logic          w_le_max;
    logic          w_in_window;
    logic          w_accept;
    logic          w_end;

    // line accumulators
    logic [DW-1:0] r_thr;
    logic [DW-1:0] r_cur_max;
    logic [PW-1:0] r_plat_start;
    logic [PW-1:0] r_plat_end;
    logic          r_run_active;
    logic [PW-1:0] r_prev_pos;
    logic          r_hit;
    logic [PW-1:0] r_af;
    logic [PW-1:0] r_al;
    logic [PW:0]   r_ac;

    // accumulator values including the sample currently presented
    logic [DW-1:0] w_nxt_max;
    logic [PW-1:0] w_nxt_ps;
    logic [PW-1:0] w_nxt_pe;
    logic          w_nxt_run;
    logic [PW-1:0] w_nxt_prev;
    logic          w_nxt_hit;
    logic [PW-1:0] w_nxt_af;
    logic [PW-1:0] w_nxt_al;
    logic [PW:0]   w_nxt_ac;
    logic [PW:0]   w_sum;
    logic [PW:0]   w_len;

    // output registers
    logic [DW-1:0] r_max_value;
    logic [PW-1:0] r_max_pos;
    logic [PW:0]   r_plateau_len;
    logic [PW-1:0] r_above_first;
    logic [PW-1:0] r_above_last;
    logic [PW:0]   r_above_count;

    // Window bounds that cover the whole position range collapse to constants
    // so no always-true unsigned compare is generated.
    generate
        if (POS_MIN <= 0) begin : g_min_open
            assign w_ge_min = 1'b1;
        end else begin : g_min_cmp
            assign w_ge_min = (data_pos >= PW'(POS_MIN));
        end
        if (POS_MAX >= (1 << PW) - 1) begin : g_max_open
            assign w_le_max = 1'b1;
        end else begin : g_max_cmp
            assign w_le_max = (data_pos <= PW'(POS_MAX));
        end
    endgenerate

    assign w_in_window = w_ge_min && w_le_max;
    assign w_accept    = (r_state == S_SCAN) && data_valid && !start && w_in_window;
    // line_end ends the line even when its position is masked out
    assign w_end       = (r_state == S_SCAN) && data_valid && !start && line_end;

    // next-state decode: start overrides everything
    always_comb begin
        w_nxt_state = r_state;
        if (start) begin
            w_nxt_state = S_SCAN;
        end else begin
            case (r_state)
                S_SCAN:  if (w_end) w_nxt_state = S_DONE;
                S_DONE:  w_nxt_state = S_IDLE;
                default: w_nxt_state = S_IDLE;
            endcase
        end
    end

    // state register, registered busy and result strobe
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_busy         <= (w_nxt_state == S_SCAN);
            r_result_valid <= w_end;
        end
    end

    // Accumulator update folded into combinational "next" values so the
    // line_end sample's contribution reaches the output registers on the
    // same edge that accepts it.
    always_comb begin
        w_nxt_max  = r_cur_max;
        w_nxt_ps   = r_plat_start;
        w_nxt_pe   = r_plat_end;
        w_nxt_run  = r_run_active;
        w_nxt_prev = r_prev_pos;
        w_nxt_hit  = r_hit;
        w_nxt_af   = r_af;
        w_nxt_al   = r_al;
        w_nxt_ac   = r_ac;
        if (w_accept) begin
            w_nxt_prev = data_pos;
            if (data_in > r_cur_max) begin
                w_nxt_max = data_in;
                w_nxt_ps  = data_pos;
                w_nxt_pe  = data_pos;
                w_nxt_run = 1'b1;
            end else if ((data_in == r_cur_max) && r_run_active &&
                         ({1'b0, data_pos} == ({1'b0, r_prev_pos} + ONE_P))) begin
                w_nxt_pe = data_pos;
            end else begin
                w_nxt_run = 1'b0;
            end
            if (data_in > r_thr) begin
                if (!r_hit) begin
                    w_nxt_af = data_pos;
                end
                w_nxt_hit = 1'b1;
                w_nxt_al  = data_pos;
                if (r_ac != '1) begin
                    w_nxt_ac = r_ac + ONE_P;
                end
            end
        end
    end

    // derived results: plateau midpoint and length (zero when no max seen)
    always_comb begin
        w_sum = {1'b0, w_nxt_ps} + {1'b0, w_nxt_pe};
        w_len = '0;
        if (w_nxt_max != '0) begin
            w_len = {1'b0, w_nxt_pe} - {1'b0, w_nxt_ps} + ONE_P;
        end
    end

    // accumulators: cleared and threshold latched on start, updated on accept
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_thr        <= '0;
            r_cur_max    <= '0;
            r_plat_start <= '0;
            r_plat_end   <= '0;
            r_run_active <= 1'b0;
            r_prev_pos   <= '0;
            r_hit        <= 1'b0;
            r_af         <= '0;
            r_al         <= '0;
            r_ac         <= '0;
        end else if (start) begin
            r_thr        <= threshold;
            r_cur_max    <= '0;
            r_plat_start <= '0;
            r_plat_end   <= '0;
            r_run_active <= 1'b0;
            r_prev_pos   <= '0;
            r_hit        <= 1'b0;
            r_af         <= '0;
            r_al         <= '0;
            r_ac         <= '0;
        end else if (w_accept) begin
            r_cur_max    <= w_nxt_max;
            r_plat_start <= w_nxt_ps;
            r_plat_end   <= w_nxt_pe;
            r_run_active <= w_nxt_run;
            r_prev_pos   <= w_nxt_prev;
            r_hit        <= w_nxt_hit;
            r_af         <= w_nxt_af;
            r_al         <= w_nxt_al;
            r_ac         <= w_nxt_ac;
        end
    end

    // result registers: load at line end, hold otherwise
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_max_value   <= '0;
            r_max_pos     <= '0;
            r_plateau_len <= '0;
            r_above_first <= '0;
            r_above_last  <= '0;
            r_above_count <= '0;
        end else if (w_end) begin
            r_max_value   <= w_nxt_max;
            r_max_pos     <= w_sum[PW:1];
            r_plateau_len <= w_len;
            r_above_first <= w_nxt_af;
            r_above_last  <= w_nxt_al;
            r_above_count <= w_nxt_ac;
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign max_value    = r_max_value;
    assign max_pos      = r_max_pos;
    assign plateau_len  = r_plateau_len;
    assign above_first  = r_above_first;
    assign above_last   = r_above_last;
    assign above_count  = r_above_count;

endmodule
